seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, handshaked successor to the team's 16-bit combinational ALU.
- Registers every result and drives a flag set (carry, zero, negative, overflow).
- Adds barrel shifts by variable amount, arithmetic right shift, and a multi-cycle iterative multiply.
- Sits between the ID/EX pipeline register and the EX/MEM register; valid/ready handshakes let the pipeline stall on multiply.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a power of 2, minimum 4.
- SHW, $clog2(WIDTH), derived shift-amount width; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block accepts the operation this cycle.
- opcode  input  4  operation select (see Behaviour).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; shift ops use b[SHW-1:0] only.
- out_valid  output  1  result registers hold an unconsumed result.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  registered result.
- carry  output  1  carry / last bit shifted out.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].
- overflow  output  1  signed overflow (ADD/SUB only, else 0).
- illegal  output  1  opcode was 10..15.

Behaviour:
- Clocking: one clock; reset is synchronous, active-high.
- Reset values: out_valid=0, result=0, all flags=0, illegal=0, FSM=IDLE, multiplier counter=0.
- Reset mid-multiply aborts the multiply; no result is produced.
- Opcodes and results:
  - 0 ADD: a+b; carry=cout.
  - 1 SUB: a+~b+1; carry=cout, so 1 means no borrow.
  - 2 AND, 3 OR, 4 XOR: bitwise; carry=0.
  - 5 GT: unsigned a>b, zero-extended to WIDTH; carry=0.
  - 6 SHL: a<<b[SHW-1:0]; carry=last bit shifted out.
  - 7 SHR: logical a>>b[SHW-1:0]; carry=last bit shifted out.
  - 8 SRA: arithmetic a>>>b[SHW-1:0]; carry=last bit shifted out.
  - For opcodes 6–8, a shift amount of 0 gives result=a and carry=0.
  - 9 MUL: low WIDTH bits of unsigned a*b; carry=1 if the upper WIDTH bits are nonzero.
  - 10..15: result=0, carry=0, illegal=1.
- Flags: overflow is set for ADD when sign(a)==sign(b) and sign(result)!=sign(a); for SUB when sign(a)!=sign(b) and sign(result)!=sign(a). zero and negative are computed from the final result for all opcodes.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Output holds stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new result loads the same cycle.
- Latency:
  - Non-MUL: result and out_valid appear the cycle after accept.
  - Back-to-back throughput is 1 op/cycle when out_ready stays high.
- FSM states IDLE, MUL:
  - IDLE to MUL on accept with opcode 9. Operands latch; the partial product is cleared; the counter is loaded with WIDTH.
  - In MUL, each cycle: if multiplier LSB=1, add multiplicand to the upper half of the 2*WIDTH accumulator; shift right 1; decrement the counter.
  - When the counter reaches 0, load the output registers, set out_valid, and return to IDLE.
  - MUL is entered only when the output slot will be free, so no extra blocking is needed.
  - Total MUL latency is WIDTH+1 cycles from accept to out_valid; in_ready=0 throughout.
- Simultaneous events:
  - out_ready and a new accept in the same cycle: the new result replaces the old and out_valid stays 1.
  - in_valid while in_ready=0: ignored; the upstream stage holds its operands.

Decomposition:
- Package seq_alu_pkg holds:
  - opcode localparams OP_ADD..OP_MUL;
  - FSM state encoding (IDLE=0, MUL=1);
  - flag bit positions for the EX/MEM flag bundle.
- Sub-module seq_mul_unit holds the shift-add accumulator and counter. Interface: start, a, b → done, product[2*WIDTH-1:0].
- The combinational ops remain inline in seq_alu.

Test Plan:
- WIDTH=16, ADD 0x7FFF+0x0001 → result=0x8000, overflow=1, negative=1, carry=0, 1-cycle latency.
- SUB 0x0003-0x0005 → 0xFFFE, carry=0 (borrow), negative=1; SUB 0x0005-0x0005 → 0x0000, zero=1, carry=1.
- SRA 0x8010 by 4 → 0xF801, carry=0; SHL 0x8001 by 1 → 0x0002, carry=1; SHR shift 0 → result=a, carry=0.
- MUL 0x0100*0x0100 → result=0x0000, carry=1, zero=1, out_valid exactly 17 cycles after accept, in_ready=0 throughout.
- Back-pressure: hold out_ready=0 after an ADD → in_ready=0, result stable; release → next op accepted the same cycle.
- Assert rst at MUL cycle 5 → next cycle out_valid=0, in_ready=1; opcode 12 → result=0, illegal=1.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encoding and
// the bit layout of the flag bundle handed to the EX/MEM register.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_GT  = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Flag bundle bit positions
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_I = 4;
  localparam int FLAG_W = 5;

  // Opcodes above MUL are unassigned
  function automatic logic is_illegal(input logic [3:0] op);
    return (op > OP_MUL);
  endfunction

  // Assemble the flag bundle in its canonical bit order
  function automatic logic [FLAG_W-1:0] pack_flags(
    input logic c, input logic z, input logic n, input logic v, input logic i);
    logic [FLAG_W-1:0] f;
    f = '0;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    f[FLAG_I] = i;
    return f;
  endfunction

endpackage

// File: rtl/seq_mul_unit.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// The accumulator's low half starts as the multiplier and is consumed
// from the LSB while the partial product grows into the high half.
module seq_mul_unit #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;

  assign addend   = acc_reg[0] ? mcand_reg : '0;
  assign sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign acc_next = {sum, acc_reg[WIDTH-1:1]};

  // done marks the cycle doing the last step; product is that step's
  // outcome so the parent can capture it on the same edge
  assign done    = (cnt_reg == CW'(1));
  assign product = acc_next;

  // Load operands on start, then one add/shift step per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_reg <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else if (start) begin
      mcand_reg <= a;
      acc_reg   <= {{WIDTH{1'b0}}, b};
      cnt_reg   <= CW'(WIDTH);
    end else if (cnt_reg != '0) begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked, registered ALU with flags. Single-cycle ops complete the
// cycle after accept; MUL runs on seq_mul_unit and stalls the input side.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             illegal
);

  state_t              state_reg;
  logic                out_valid_reg;
  logic [WIDTH-1:0]    result_reg;
  logic [FLAG_W-1:0]   flags_reg;

  logic                accept;
  logic                mul_start;
  logic                mul_done;
  logic [2*WIDTH-1:0]  mul_product;
  logic [FLAG_W-1:0]   mul_flags;

  logic [SHW-1:0]      amt;
  logic [WIDTH:0]      sum_ext;
  logic [WIDTH:0]      diff_ext;
  logic [WIDTH:0]      shl_ext;
  logic [WIDTH:0]      shr_ext;
  logic signed [WIDTH:0] sra_ext;
  logic [WIDTH-1:0]    and_v;
  logic [WIDTH-1:0]    or_v;
  logic [WIDTH-1:0]    xor_v;

  logic [WIDTH-1:0]    res_c;
  logic                carry_c;
  logic                ovf_c;
  logic [FLAG_W-1:0]   flags_c;

  // Output slot must be free (or draining) and no multiply in flight
  assign in_ready  = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == OP_MUL);

  seq_mul_unit #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Carry-out sits in the extra top bit of the extended sums
  assign amt      = b[SHW-1:0];
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  // The guard bit beside a collects the last bit shifted out; with a
  // zero shift amount it stays 0
  assign shl_ext = {1'b0, a} << amt;
  assign shr_ext = {a, 1'b0} >> amt;
  assign sra_ext = $signed({a, 1'b0}) >>> amt;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign and_v[gi] = a[gi] & b[gi];
      assign or_v[gi]  = a[gi] | b[gi];
      assign xor_v[gi] = a[gi] ^ b[gi];
    end
  endgenerate

  // Single-cycle result, carry and overflow selection
  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (opcode)
      OP_ADD: begin
        res_c   = sum_ext[WIDTH-1:0];
        carry_c = sum_ext[WIDTH];
        ovf_c   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c   = diff_ext[WIDTH-1:0];
        carry_c = diff_ext[WIDTH];
        ovf_c   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res_c = and_v;
      OP_OR:  res_c = or_v;
      OP_XOR: res_c = xor_v;
      OP_GT:  res_c = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_SHL: begin
        res_c   = shl_ext[WIDTH-1:0];
        carry_c = shl_ext[WIDTH];
      end
      OP_SHR: begin
        res_c   = shr_ext[WIDTH:1];
        carry_c = shr_ext[0];
      end
      OP_SRA: begin
        res_c   = sra_ext[WIDTH:1];
        carry_c = sra_ext[0];
      end
      default: begin
        res_c   = '0;
        carry_c = 1'b0;
      end
    endcase
  end

  assign flags_c = pack_flags(carry_c, (res_c == '0), res_c[WIDTH-1], ovf_c,
                              is_illegal(opcode));

  assign mul_flags = pack_flags(|mul_product[2*WIDTH-1:WIDTH],
                                (mul_product[WIDTH-1:0] == '0),
                                mul_product[WIDTH-1], 1'b0, 1'b0);

  // Control FSM and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      flags_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (opcode == OP_MUL) begin
              // Any previous result is being consumed this cycle
              state_reg     <= ST_MUL;
              out_valid_reg <= 1'b0;
            end else begin
              result_reg    <= res_c;
              flags_reg     <= flags_c;
              out_valid_reg <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            result_reg    <= mul_product[WIDTH-1:0];
            flags_reg     <= mul_flags;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign carry     = flags_reg[FLAG_C];
  assign zero      = flags_reg[FLAG_Z];
  assign negative  = flags_reg[FLAG_N];
  assign overflow  = flags_reg[FLAG_V];
  assign illegal   = flags_reg[FLAG_I];

endmodule
